// File: rtl/poly_add_seq.sv
`default_nettype none
// ============================================================================
// Module   : poly_add_seq
// Brief    : Sequencer for the dual-lane modular polynomial adder. Streams
//            len packed words of operand A and operand B from two
//            synchronous-read RAMs into the adder. Writes the adder results
//            to the destination RAM. Pulses done after the last write.
// Revision : 1.0 - initial release
// ============================================================================
module poly_add_seq #(
  parameter int AW = 8,   // address width of all three RAM ports
  parameter int LW = 8,   // width of the word-count field
  parameter int DW = 50   // packed data width (2 x 25-bit coefficients)
) (
  input  logic          clk,
  input  logic          rst,          // asynchronous, active low

  // job request
  input  logic          start,
  input  logic          q_mod,
  input  logic [LW-1:0] len,
  input  logic [AW-1:0] a_base,
  input  logic [AW-1:0] b_base,
  input  logic [AW-1:0] d_base,

  // operand A RAM
  output logic          a_rd_en,
  output logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_rdata,

  // operand B RAM
  output logic          b_rd_en,
  output logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_rdata,

  // adder interface
  output logic          add_in_flag,
  output logic          add_q_mod,
  output logic [DW-1:0] add_din1,
  output logic [DW-1:0] add_din2,
  input  logic [DW-1:0] add_dout,
  input  logic          add_out_flag,

  // destination RAM
  output logic          d_wr_en,
  output logic [AW-1:0] d_addr,
  output logic [DW-1:0] d_wdata,

  // status
  output logic          busy,
  output logic          done
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [1:0] C_IDLE  = 2'd0;
  localparam logic [1:0] C_RUN   = 2'd1;
  localparam logic [1:0] C_DRAIN = 2'd2;
  localparam logic [1:0] C_FIN   = 2'd3;

  // --------------------------------------------------------------------------
  // Registers (q) and their next values (d)
  // --------------------------------------------------------------------------
  logic [1:0]    state_q,  state_d;
  logic [LW-1:0] len_q,    len_d;
  logic [AW-1:0] a_base_q, a_base_d;
  logic [AW-1:0] b_base_q, b_base_d;
  logic [AW-1:0] d_base_q, d_base_d;
  logic          q_mod_q,  q_mod_d;
  logic [LW-1:0] rd_cnt_q, rd_cnt_d;
  logic [LW-1:0] wr_cnt_q, wr_cnt_d;
  logic          rd_vld_q, rd_vld_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic          w_accept;    // start taken this cycle
  logic          w_rd_issue;  // read strobe this cycle
  logic          w_rd_last;   // this read carries index len-1
  logic          w_active;    // job owns the write port
  logic          w_wr_accept; // result accepted into destination RAM
  logic [AW-1:0] w_rd_off;    // read count resized to address width
  logic [AW-1:0] w_wr_off;    // write count resized to address width

  assign w_accept    = (state_q == C_IDLE) && start;
  assign w_rd_issue  = (state_q == C_RUN);
  assign w_rd_last   = w_rd_issue && (rd_cnt_q == (len_q - LW'(1)));
  assign w_active    = (state_q == C_RUN) || (state_q == C_DRAIN);
  // Results beyond len (or after an abort) never reach the RAM.
  assign w_wr_accept = w_active && add_out_flag && (wr_cnt_q < len_q);

  // Counters are resized to the address width; the sum wraps modulo 2^AW.
  generate
    if (LW >= AW) begin : g_off_trunc
      assign w_rd_off = rd_cnt_q[AW-1:0];
      assign w_wr_off = wr_cnt_q[AW-1:0];
    end else begin : g_off_ext
      assign w_rd_off = {{(AW-LW){1'b0}}, rd_cnt_q};
      assign w_wr_off = {{(AW-LW){1'b0}}, wr_cnt_q};
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State register and job registers; reset aborts any job immediately
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= C_IDLE;
      len_q    <= '0;
      a_base_q <= '0;
      b_base_q <= '0;
      d_base_q <= '0;
      q_mod_q  <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      a_base_q <= a_base_d;
      b_base_q <= b_base_d;
      d_base_q <= d_base_d;
      q_mod_q  <= q_mod_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      rd_vld_q <= rd_vld_d;
    end
  end

  // Next-state logic: DRAIN exits on the cycle the final result is written
  always_comb begin
    state_d = state_q;
    case (state_q)
      C_IDLE:  if (start) state_d = (len == '0) ? C_FIN : C_RUN;
      C_RUN:   if (w_rd_last) state_d = C_DRAIN;
      C_DRAIN: if (wr_cnt_d == len_q) state_d = C_FIN;
      C_FIN:   state_d = C_IDLE;
      default: state_d = C_IDLE;
    endcase
  end

  // Job parameters latch only when a start is accepted in IDLE
  always_comb begin
    len_d    = len_q;
    a_base_d = a_base_q;
    b_base_d = b_base_q;
    d_base_d = d_base_q;
    q_mod_d  = q_mod_q;
    if (w_accept) begin
      len_d    = len;
      a_base_d = a_base;
      b_base_d = b_base;
      d_base_d = d_base;
      q_mod_d  = q_mod;
    end
  end

  // Read/write counters and the read-valid pipeline stage
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (w_accept) begin
      rd_cnt_d = '0;
      wr_cnt_d = '0;
    end else begin
      if (w_rd_issue)  rd_cnt_d = rd_cnt_q + LW'(1);
      if (w_wr_accept) wr_cnt_d = wr_cnt_q + LW'(1);
    end
    // RAM data appears one cycle after the strobe, so the adder's valid
    // follows the strobe by one cycle.
    rd_vld_d = w_rd_issue;
  end

  // Output decode from the current state and registered job context
  always_comb begin
    a_rd_en     = w_rd_issue;
    b_rd_en     = w_rd_issue;
    a_addr      = a_base_q + w_rd_off;
    b_addr      = b_base_q + w_rd_off;
    add_in_flag = rd_vld_q;
    add_q_mod   = q_mod_q;
    add_din1    = a_rdata;
    add_din2    = b_rdata;
    d_wr_en     = w_wr_accept;
    d_addr      = d_base_q + w_wr_off;
    d_wdata     = add_dout;
    busy        = w_active;
    done        = (state_q == C_FIN);
  end

endmodule
`default_nettype wire

// File: tb/tb_poly_add_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_poly_add_seq
// Brief    : Directed bench for poly_add_seq with RAM and adder models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_poly_add_seq;
  localparam int AW = 8;
  localparam int LW = 8;
  localparam int DW = 50;
  localparam logic [25:0] Q = 26'd33292289;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          q_mod = 1'b0;
  logic [LW-1:0] len = '0;
  logic [AW-1:0] a_base = '0, b_base = '0, d_base = '0;
  logic          a_rd_en, b_rd_en, add_in_flag, add_q_mod, d_wr_en, busy, done;
  logic [AW-1:0] a_addr, b_addr, d_addr;
  logic [DW-1:0] a_rdata, b_rdata, add_din1, add_din2, add_dout, d_wdata;
  logic          add_out_flag;

  poly_add_seq #(.AW(AW), .LW(LW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .q_mod(q_mod), .len(len),
    .a_base(a_base), .b_base(b_base), .d_base(d_base),
    .a_rd_en(a_rd_en), .a_addr(a_addr), .a_rdata(a_rdata),
    .b_rd_en(b_rd_en), .b_addr(b_addr), .b_rdata(b_rdata),
    .add_in_flag(add_in_flag), .add_q_mod(add_q_mod),
    .add_din1(add_din1), .add_din2(add_din2),
    .add_dout(add_dout), .add_out_flag(add_out_flag),
    .d_wr_en(d_wr_en), .d_addr(d_addr), .d_wdata(d_wdata),
    .busy(busy), .done(done)
  );

  // RAM models: synchronous read, data one cycle after the strobe
  logic [DW-1:0] mem_a [256];
  logic [DW-1:0] mem_b [256];
  logic [DW-1:0] a_q = '0, b_q = '0;
  always @(posedge clk) begin
    if (a_rd_en) a_q <= mem_a[a_addr];
    if (b_rd_en) b_q <= mem_b[b_addr];
  end
  assign a_rdata = a_q;
  assign b_rdata = b_q;

  function automatic logic [DW-1:0] lane_add(input logic [DW-1:0] x, input logic [DW-1:0] y);
    logic [25:0] h, l;
    h = {1'b0, x[49:25]} + {1'b0, y[49:25]};
    if (h >= Q) h = h - Q;
    l = {1'b0, x[24:0]} + {1'b0, y[24:0]};
    if (l >= Q) l = l - Q;
    return {h[24:0], l[24:0]};
  endfunction

  // Adder model: 2-cycle latency from in_flag to out_flag
  logic          s1_v = 1'b0, s2_v = 1'b0;
  logic [DW-1:0] s1_d = '0, s2_d = '0;
  always @(posedge clk) begin
    s1_v <= add_in_flag;
    s1_d <= lane_add(add_din1, add_din2);
    s2_v <= s1_v;
    s2_d <= s1_d;
  end
  assign add_out_flag = s2_v;
  assign add_dout     = s2_d;

  int checks = 0;
  int errors = 0;

  // Per-job observation record (cycle 0 = cycle in which start is sampled)
  int n_rd, rd_first, rd_last, n_inf, inf_first, inf_last;
  int n_wr, n_done, done_cyc, n_busy, busy_first, busy_last, qm_bad;
  logic [AW-1:0] rd_a_log [256];
  logic [AW-1:0] rd_b_log [256];
  logic [AW-1:0] wr_addr_log [256];
  logic [DW-1:0] wr_data_log [256];
  int            wr_cyc_log [256];

  task automatic run_job(input int n, input logic [7:0] ab, input logic [7:0] bb,
                         input logic [7:0] db, input logic qm, input int lim,
                         input int inj1, input int inj2);
    n_rd = 0; rd_first = -1; rd_last = -1; n_inf = 0; inf_first = -1; inf_last = -1;
    n_wr = 0; n_done = 0; done_cyc = -1; n_busy = 0; busy_first = -1; busy_last = -1;
    qm_bad = 0;
    for (int i = 0; i < 256; i++) begin
      rd_a_log[i] = 'x; rd_b_log[i] = 'x; wr_addr_log[i] = 'x; wr_data_log[i] = 'x;
      wr_cyc_log[i] = -1;
    end
    len = LW'(n); a_base = ab; b_base = bb; d_base = db; q_mod = qm; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= lim; k++) begin
      @(negedge clk);
      if (a_rd_en === 1'b1) begin
        if (n_rd < 256) begin rd_a_log[n_rd] = a_addr; rd_b_log[n_rd] = b_addr; end
        if (rd_first < 0) rd_first = k;
        rd_last = k; n_rd++;
      end
      if (add_in_flag === 1'b1) begin
        if (inf_first < 0) inf_first = k;
        inf_last = k; n_inf++;
      end
      if (d_wr_en === 1'b1) begin
        if (n_wr < 256) begin
          wr_addr_log[n_wr] = d_addr; wr_data_log[n_wr] = d_wdata; wr_cyc_log[n_wr] = k;
        end
        n_wr++;
      end
      if (done === 1'b1) begin n_done++; done_cyc = k; end
      if (busy === 1'b1) begin
        if (busy_first < 0) busy_first = k;
        busy_last = k; n_busy++;
        if (add_q_mod !== qm) qm_bad++;
      end
      if (k == inj1 || k == inj2) begin
        start = 1'b1; len = 8'd3; a_base = 8'h99; b_base = 8'h99; d_base = 8'h99; q_mod = ~qm;
      end else begin
        start = 1'b0; len = LW'(n); a_base = ab; b_base = bb; d_base = db; q_mod = qm;
      end
    end
    start = 1'b0;
  endtask

  function automatic int bad_writes(input int n, input logic [7:0] ab, input logic [7:0] bb,
                                    input logic [7:0] db);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      logic [7:0] ia, ib, id;
      ia = ab + 8'(i); ib = bb + 8'(i); id = db + 8'(i);
      if (wr_addr_log[i] !== id || wr_data_log[i] !== lane_add(mem_a[ia], mem_b[ib])
          || wr_cyc_log[i] != 4 + i) bad++;
    end
    return bad;
  endfunction

  function automatic int bad_reads(input int n, input logic [7:0] ab, input logic [7:0] bb);
    int bad = 0;
    for (int i = 0; i < n; i++)
      if (rd_a_log[i] !== ab + 8'(i) || rd_b_log[i] !== bb + 8'(i)) bad++;
    return bad;
  endfunction

  task automatic test_reset();
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({a_rd_en, b_rd_en, add_in_flag, add_q_mod, d_wr_en, busy, done} !== 7'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b expected 0000000",
               {a_rd_en, b_rd_en, add_in_flag, add_q_mod, d_wr_en, busy, done});
    end
    checks++;
    if ({a_addr, b_addr, d_addr} !== 24'h0) begin
      errors++; $display("FAIL reset_addr: got %h expected 000000", {a_addr, b_addr, d_addr});
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int bad;
    mem_a[8'h00] = {25'd33292288, 25'd5};
    mem_b[8'h10] = {25'd1, 25'd7};
    run_job(1, 8'h00, 8'h10, 8'h20, 1'b1, 7, -1, -1);
    checks++;
    if (n_wr != 1 || wr_addr_log[0] !== 8'h20 || wr_cyc_log[0] != 4) begin
      errors++;
      $display("FAIL single_write: got n=%0d addr=%h cyc=%0d expected n=1 addr=20 cyc=4",
               n_wr, wr_addr_log[0], wr_cyc_log[0]);
    end
    checks++;
    if (wr_data_log[0] !== {25'd0, 25'd12}) begin
      errors++; $display("FAIL single_data: got %h expected %h", wr_data_log[0], {25'd0, 25'd12});
    end
    checks++;
    if (n_done != 1 || done_cyc != 5) begin
      errors++; $display("FAIL single_done: got n=%0d cyc=%0d expected n=1 cyc=5", n_done, done_cyc);
    end
    checks++;
    if (n_busy != 4 || busy_first != 1 || busy_last != 4 || qm_bad != 0) begin
      errors++;
      $display("FAIL single_busy: got n=%0d %0d..%0d qm_bad=%0d expected n=4 1..4 qm_bad=0",
               n_busy, busy_first, busy_last, qm_bad);
    end
    bad = bad_reads(1, 8'h00, 8'h10);
    checks++;
    if (n_rd != 1 || rd_first != 1 || bad != 0) begin
      errors++; $display("FAIL single_read: got n=%0d first=%0d bad=%0d expected 1 1 0", n_rd, rd_first, bad);
    end
  endtask

  task automatic test_full();
    int bw, br;
    for (int i = 0; i < 128; i++) begin
      mem_a[i]       = {25'($urandom_range(33292288, 0)), 25'($urandom_range(33292288, 0))};
      mem_b[128 + i] = {25'($urandom_range(33292288, 0)), 25'($urandom_range(33292288, 0))};
    end
    mem_a[5]   = {25'd33292288, 25'd33292288};
    mem_b[133] = {25'd33292288, 25'd1};
    run_job(128, 8'h00, 8'h80, 8'h40, 1'b1, 134, -1, -1);
    bw = bad_writes(128, 8'h00, 8'h80, 8'h40);
    br = bad_reads(128, 8'h00, 8'h80);
    checks++;
    if (n_wr != 128 || bw != 0) begin
      errors++; $display("FAIL full_writes: got n=%0d bad=%0d expected n=128 bad=0", n_wr, bw);
    end
    checks++;
    if (n_rd != 128 || rd_first != 1 || rd_last != 128 || br != 0) begin
      errors++;
      $display("FAIL full_reads: got n=%0d %0d..%0d bad=%0d expected 128 1..128 0", n_rd, rd_first, rd_last, br);
    end
    checks++;
    if (n_inf != 128 || inf_first != 2 || inf_last != 129) begin
      errors++;
      $display("FAIL full_in_flag: got n=%0d %0d..%0d expected 128 2..129", n_inf, inf_first, inf_last);
    end
    checks++;
    if (n_done != 1 || done_cyc != 132) begin
      errors++; $display("FAIL full_done: got n=%0d cyc=%0d expected 1 132", n_done, done_cyc);
    end
    checks++;
    if (wr_data_log[5] !== {25'd33292287, 25'd0}) begin
      errors++; $display("FAIL full_mod_edge: got %h expected %h", wr_data_log[5], {25'd33292287, 25'd0});
    end
  endtask

  task automatic test_len_zero();
    run_job(0, 8'h05, 8'h06, 8'h07, 1'b1, 3, -1, -1);
    checks++;
    if (n_rd != 0 || n_inf != 0 || n_wr != 0 || n_busy != 0) begin
      errors++;
      $display("FAIL zero_activity: got rd=%0d inf=%0d wr=%0d busy=%0d expected all 0", n_rd, n_inf, n_wr, n_busy);
    end
    checks++;
    if (n_done != 1 || done_cyc != 1) begin
      errors++; $display("FAIL zero_done: got n=%0d cyc=%0d expected 1 1", n_done, done_cyc);
    end
  endtask

  task automatic test_wrap();
    int bw;
    mem_a[8'hFE] = {25'd100, 25'd200};      mem_b[8'h10] = {25'd33292200, 25'd1};
    mem_a[8'hFF] = {25'd300, 25'd33292280}; mem_b[8'h11] = {25'd4, 25'd20};
    mem_a[8'h00] = {25'd7, 25'd8};          mem_b[8'h12] = {25'd9, 25'd10};
    mem_a[8'h01] = {25'd0, 25'd0};          mem_b[8'h13] = {25'd33292288, 25'd33292288};
    run_job(4, 8'hFE, 8'h10, 8'hFF, 1'b1, 9, -1, -1);
    checks++;
    if ({rd_a_log[0], rd_a_log[1], rd_a_log[2], rd_a_log[3]} !== 32'hFEFF0001) begin
      errors++;
      $display("FAIL wrap_rd_addr: got %h expected FEFF0001",
               {rd_a_log[0], rd_a_log[1], rd_a_log[2], rd_a_log[3]});
    end
    checks++;
    if ({wr_addr_log[0], wr_addr_log[1], wr_addr_log[2], wr_addr_log[3]} !== 32'hFF000102) begin
      errors++;
      $display("FAIL wrap_wr_addr: got %h expected FF000102",
               {wr_addr_log[0], wr_addr_log[1], wr_addr_log[2], wr_addr_log[3]});
    end
    checks++;
    if (wr_data_log[1] !== {25'd304, 25'd33292300 - 25'd33292289}) begin
      errors++; $display("FAIL wrap_data1: got %h expected %h", wr_data_log[1], {25'd304, 25'd11});
    end
    bw = bad_writes(4, 8'hFE, 8'h10, 8'hFF);
    checks++;
    if (n_wr != 4 || bw != 0 || done_cyc != 8) begin
      errors++; $display("FAIL wrap_job: got n=%0d bad=%0d done=%0d expected 4 0 8", n_wr, bw, done_cyc);
    end
  endtask

  task automatic test_start_ignored();
    int br, bw;
    for (int i = 0; i < 6; i++) begin
      mem_a[8'h20 + i] = {25'(i + 1), 25'(i * 3)};
      mem_b[8'h30 + i] = {25'(33292280 + i), 25'(i)};
    end
    // start during RUN (cycle 3) and during FIN (cycle 10); run through cycle 11
    run_job(6, 8'h20, 8'h30, 8'h50, 1'b1, 11, 3, 10);
    br = bad_reads(6, 8'h20, 8'h30);
    bw = bad_writes(6, 8'h20, 8'h30, 8'h50);
    checks++;
    if (n_rd != 6 || br != 0 || n_wr != 6 || bw != 0) begin
      errors++;
      $display("FAIL ign_relatch: got rd=%0d rbad=%0d wr=%0d wbad=%0d expected 6 0 6 0", n_rd, br, n_wr, bw);
    end
    checks++;
    if (n_done != 1 || done_cyc != 10 || n_busy != 9 || busy_last != 9 || qm_bad != 0) begin
      errors++;
      $display("FAIL ign_status: got done=%0d@%0d busy=%0d last=%0d qm_bad=%0d expected 1@10 9 9 0",
               n_done, done_cyc, n_busy, busy_last, qm_bad);
    end
    // fresh job whose start is in the cycle right after FIN
    mem_a[8'h40] = {25'd11, 25'd12}; mem_a[8'h41] = {25'd13, 25'd14};
    mem_b[8'h60] = {25'd1,  25'd2};  mem_b[8'h61] = {25'd3,  25'd4};
    run_job(2, 8'h40, 8'h60, 8'h70, 1'b0, 8, -1, -1);
    br = bad_reads(2, 8'h40, 8'h60);
    checks++;
    if (rd_first != 1 || n_rd != 2 || br != 0 || qm_bad != 0) begin
      errors++;
      $display("FAIL b2b_reads: got first=%0d n=%0d bad=%0d qm_bad=%0d expected 1 2 0 0", rd_first, n_rd, br, qm_bad);
    end
    checks++;
    if (n_wr != 2 || wr_addr_log[1] !== 8'h71 || wr_data_log[1] !== {25'd16, 25'd18} || done_cyc != 6) begin
      errors++;
      $display("FAIL b2b_writes: got n=%0d addr=%h data=%h done=%0d expected 2 71 %h 6",
               n_wr, wr_addr_log[1], wr_data_log[1], done_cyc, {25'd16, 25'd18});
    end
  endtask

  task automatic test_reset_mid();
    int stray, bw;
    stray = 0;
    len = 8'd64; a_base = 8'h00; b_base = 8'h80; d_base = 8'h10; q_mod = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 10; k++) @(negedge clk);
    checks++;
    if (a_rd_en !== 1'b1 || d_wr_en !== 1'b1) begin
      errors++; $display("FAIL mid_active: got rd=%b wr=%b expected 1 1", a_rd_en, d_wr_en);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({a_rd_en, b_rd_en, add_in_flag, d_wr_en, busy, done} !== 6'b0) begin
      errors++;
      $display("FAIL mid_abort: got %b expected 000000", {a_rd_en, b_rd_en, add_in_flag, d_wr_en, busy, done});
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0 || a_rd_en !== 1'b0 || d_wr_en !== 1'b0) stray++;
    end
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0 || a_rd_en !== 1'b0 || d_wr_en !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++; $display("FAIL mid_quiet: got %0d stray cycles expected 0", stray);
    end
    run_job(2, 8'h04, 8'h84, 8'h30, 1'b1, 7, -1, -1);
    bw = bad_writes(2, 8'h04, 8'h84, 8'h30);
    checks++;
    if (n_wr != 2 || bw != 0 || n_done != 1 || done_cyc != 6) begin
      errors++;
      $display("FAIL mid_rerun: got wr=%0d bad=%0d done=%0d@%0d expected 2 0 1@6", n_wr, bw, n_done, done_cyc);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
    test_reset();
    test_single();
    test_full();
    test_len_zero();
    test_wrap();
    test_start_ignored();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/poly_add_seq.md
Name: poly_add_seq

Overview:
- Sequencer for the dual-lane modular polynomial adder.
- The adder takes two 25-bit coefficients packed per 50-bit word, mod q = 33292289, and has 2-cycle latency from in_flag to out_flag.
- On start, this block streams N packed words of operand A and operand B from two synchronous-read RAMs into the adder, then writes the adder results to the destination RAM.
- It signals done when the last result is written. It sits between the polynomial memory bank and the adder instance in the signing datapath.

Parameters:
- AW, 8, address width of all three RAM ports.
- LW, 8, width of the length field (word count).
- DW, 50, packed data width (2 x 25-bit coefficients).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin an addition; sampled only in IDLE.
- q_mod  in  1  modulus select; latched at start and held on add_q_mod for the whole job.
- len  in  LW  number of packed words to process; latched at start.
- a_base  in  AW  base address of operand A; latched at start.
- b_base  in  AW  base address of operand B; latched at start.
- d_base  in  AW  base address of the destination; latched at start.
- a_rd_en / b_rd_en  out  1  read strobes to the A and B RAMs.
- a_addr / b_addr  out  AW  read addresses.
- a_rdata / b_rdata  in  DW  RAM read data, valid exactly 1 cycle after the strobe.
- add_in_flag  out  1  drives adder in_flag.
- add_q_mod  out  1  drives adder q_mod.
- add_din1 / add_din2  out  DW  adder operands; combinational pass-through of a_rdata / b_rdata.
- add_dout  in  DW  adder result.
- add_out_flag  in  1  adder result valid.
- d_wr_en  out  1  destination write strobe.
- d_addr  out  AW  write address.
- d_wdata  out  DW  write data.
- busy  out  1  job in progress.
- done  out  1  single-cycle completion pulse.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE; all counters clear.
  - All strobes, busy, done, add_in_flag and add_q_mod are 0; all address outputs are 0.
- FSM states: IDLE, RUN, DRAIN, FIN.
- IDLE:
  - If start=1, latch len, bases and q_mod.
  - Go to FIN if len=0, otherwise go to RUN.
  - busy=0.
- RUN:
  - One read per cycle: a_rd_en=b_rd_en=1, a_addr=a_base+rd_cnt, b_addr=b_base+rd_cnt.
  - rd_cnt counts 0..len-1.
  - After issuing index len-1, go to DRAIN.
  - busy=1.
- Read valid:
  - rd_vld is a 1-cycle-delayed copy of the read strobe; add_in_flag = rd_vld.
  - add_in_flag is therefore high for exactly len contiguous cycles, starting 1 cycle after the first read.
- Write path:
  - d_wr_en = add_out_flag, counted only while wr_cnt < len_latched.
  - d_wdata = add_dout; d_addr = d_base + wr_cnt.
  - wr_cnt increments on each accepted write.
  - An add_out_flag seen while wr_cnt = len is ignored: no write.
- DRAIN:
  - No reads.
  - Stay until wr_cnt = len_latched, then go to FIN.
- FIN:
  - done=1 for one cycle, busy=0, return to IDLE.
  - A start in FIN is ignored; it is accepted only from IDLE on the next cycle.
- Timing, with start sampled at cycle 0 and len=N>0:
  - Reads issue in cycles 1..N.
  - add_in_flag is high in cycles 2..N+1.
  - Writes occur in cycles 4..N+3.
  - done pulses in cycle N+4.
  - busy is high in cycles 1..N+3.
- Address arithmetic:
  - base + count is modulo 2^AW; wrap past the top of the RAM is permitted and silent.
- start while busy: ignored, no relatch.
- Reset mid-job:
  - Immediate abort; no further reads or writes.
  - Partial results already written remain in RAM.
  - No done pulse.
- The add_in_flag gap after the last word lets the adder clear its internal pipeline between jobs, so back-to-back jobs never merge in the adder.

Test Plan:
- Single word:
  - Stimulus: len=1, a_base=0, b_base=0x10, d_base=0x20, A[0]={33292288,5}, B[0]={1,7}.
  - Required: one write at addr 0x20 with data {0,12}; done at cycle 5 after start; busy high in cycles 1..4.
- Full polynomial:
  - Stimulus: len=128, random coefficients < q.
  - Required: 128 writes to d_base..d_base+127 in cycles 4..131 with (a+b) mod q per lane; done at cycle 132; exactly 128 add_in_flag cycles.
- len=0:
  - Required: no rd_en, no add_in_flag, no wr_en; done pulses the cycle after start.
- Address wrap:
  - Stimulus: len=4, a_base=0xFE.
  - Required: A read addresses 0xFE, 0xFF, 0x00, 0x01.
  - Stimulus: d_base=0xFF.
  - Required: writes to 0xFF, 0x00, 0x01, 0x02.
- start ignored:
  - Stimulus: start pulsed during RUN with different bases, and again during FIN.
  - Required: neither is accepted, no relatch. A start in the cycle after FIN begins a new job with fresh parameters.
- Reset mid-job:
  - Stimulus: rst=0 at cycle 10 of a len=64 job.
  - Required: all strobes 0 in the same cycle (asynchronous), no done pulse. After release, a new len=2 job completes normally with correct addresses from wr_cnt=0.
